fifo_rd_packetizer: RTL and testbench

FIFO_RD_PACKETIZER -- requirements
Module: fifo_rd_packetizer

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/out_stage_reg.sv | 66 ++++++
 rtl/fifo_rd_packetizer.sv | 122 ++++++++++++
 tb/tb_fifo_rd_packetizer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read packetizer.
//   FIFO_FWIDTH / FIFO_FDEPTH : geometry of the upstream FIFO
//   DEF_PKT_WORDS             : default payload words per packet
//   HDR_MARKER                : top byte of every header word
//   state_e                   : packetizer FSM encoding
package fifo_pkg;

    localparam int unsigned FIFO_FWIDTH   = 32;
    localparam int unsigned FIFO_FDEPTH   = 16;
    localparam int unsigned DEF_PKT_WORDS = 4;
    localparam int unsigned SEQ_W         = 16;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned HDR_W         = 32;

    localparam logic [7:0] HDR_MARKER = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Header word: marker, payload length, sequence number.
    function automatic logic [HDR_W-1:0] make_hdr(input logic [7:0]       n_words,
                                                  input logic [SEQ_W-1:0] seq);
        return {HDR_MARKER, n_words, seq};
    endfunction

endpackage

// File: rtl/out_stage_reg.sv
// Single-entry valid/ready output register.
//   clk_i, rst_n_i : clock, async active-low reset
//   load_i         : capture data_i/sop_i/eop_i (only legal while free_c is high)
//   ready_i        : downstream accepts the held word
//   free_c         : combinational, register empty or draining this cycle
//   data_o, sop_o, eop_o, valid_o : registered outputs
module out_stage_reg #(
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          sop_i,
    input  logic          eop_i,
    input  logic          ready_i,
    output logic          free_c,
    output logic [DW-1:0] data_o,
    output logic          sop_o,
    output logic          eop_o,
    output logic          valid_o
);

    logic [DW-1:0] data_q, data_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          valid_q, valid_d;

    assign free_c = !valid_q || ready_i;

    // Load wins; otherwise a completed transfer empties the register.
    always_comb begin
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            sop_d   = sop_i;
            eop_d   = eop_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fifo_rd_packetizer.sv
// Reads a first-word-fall-through FIFO and emits packets of one header word
// followed by PKT_WORDS payload words on a valid/ready stream.
//   Clk, RstN           : clock, async active-low reset
//   F_Data, F_EmptyN    : FIFO head word and non-empty flag
//   FOutN               : FIFO read strobe, active-low, combinational
//   Enable              : allows a new packet to start (sampled in IDLE)
//   Out_Data/Valid/Sop/Eop, Out_Ready : downstream stream
//   SeqNum              : completed-packet count, wraps at 2^16
//   Busy                : FSM not in IDLE
module fifo_rd_packetizer
    import fifo_pkg::*;
#(
    parameter int unsigned FWIDTH    = FIFO_FWIDTH,
    parameter int unsigned PKT_WORDS = DEF_PKT_WORDS
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic [FWIDTH-1:0] F_Data,
    input  logic              F_EmptyN,
    output logic              FOutN,
    input  logic              Enable,
    output logic [FWIDTH-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Out_Sop,
    output logic              Out_Eop,
    output logic [15:0]       SeqNum,
    output logic              Busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_WORDS - 1);
    localparam logic [7:0]       LEN_BYTE = 8'(PKT_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;

    logic               free_c;
    logic               pop_c;
    logic               load_c;
    logic [FWIDTH-1:0]  ld_data_c;
    logic               ld_sop_c;
    logic               ld_eop_c;

    // Next state, FIFO pop and output-register load.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        pop_c     = 1'b0;
        load_c    = 1'b0;
        ld_data_c = '0;
        ld_sop_c  = 1'b0;
        ld_eop_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Enable && F_EmptyN) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (free_c) begin
                    load_c    = 1'b1;
                    ld_data_c = FWIDTH'(make_hdr(LEN_BYTE, seq_q));
                    ld_sop_c  = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                // Pop only when the word has somewhere to go this cycle.
                if (F_EmptyN && free_c) begin
                    pop_c     = 1'b1;
                    load_c    = 1'b1;
                    ld_data_c = F_Data;
                    if (cnt_q == LAST_IDX) begin
                        ld_eop_c = 1'b1;
                        cnt_d    = '0;
                        seq_d    = seq_q + SEQ_W'(1);
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
        end
    end

    out_stage_reg #(
        .DW (FWIDTH)
    ) u_out (
        .clk_i   (Clk),
        .rst_n_i (RstN),
        .load_i  (load_c),
        .data_i  (ld_data_c),
        .sop_i   (ld_sop_c),
        .eop_i   (ld_eop_c),
        .ready_i (Out_Ready),
        .free_c  (free_c),
        .data_o  (Out_Data),
        .sop_o   (Out_Sop),
        .eop_o   (Out_Eop),
        .valid_o (Out_Valid)
    );

    assign FOutN  = !pop_c;
    assign SeqNum = seq_q;
    assign Busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_rd_packetizer.sv
// Self-checking bench for fifo_rd_packetizer: a cycle table for the
// two-packet back-to-back run, then directed sequences for FIFO starvation,
// downstream backpressure, mid-packet reset, Enable drop and SeqNum wrap.
module tb_fifo_rd_packetizer;

    localparam int unsigned FW = 32;
    localparam logic [3:0]  RDY_PAT = 4'b1001;

    logic          Clk = 1'b0;
    logic          RstN;
    logic [FW-1:0] F_Data;
    logic          F_EmptyN;
    logic          FOutN;
    logic          Enable;
    logic [FW-1:0] Out_Data;
    logic          Out_Valid;
    logic          Out_Ready;
    logic          Out_Sop;
    logic          Out_Eop;
    logic [15:0]   SeqNum;
    logic          Busy;

    always #5 Clk = ~Clk;

    fifo_rd_packetizer #(
        .FWIDTH    (FW),
        .PKT_WORDS (4)
    ) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .F_Data    (F_Data),
        .F_EmptyN  (F_EmptyN),
        .FOutN     (FOutN),
        .Enable    (Enable),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Sop   (Out_Sop),
        .Out_Eop   (Out_Eop),
        .SeqNum    (SeqNum),
        .Busy      (Busy)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } xfer_t;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        es;
        logic        ee;
        logic        ef;
        logic        eb;
        logic [15:0] eseq;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fq[$];
    xfer_t       got[$];
    logic        saw_eop;
    int          pops = 0;
    logic        prev_stall;
    logic [34:0] prev_out;
    vec_t        tbl[14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        F_EmptyN = (fq.size() != 0);
        F_Data   = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // Called ~1 unit after a negedge with inputs settled; ends at next negedge.
    task automatic advance();
        logic popped;
        popped = !FOutN;
        if (!FOutN) check("fout_vs_empty", 64'(F_EmptyN), 64'(1));
        if (prev_stall) check("stall_hold", 64'({Out_Valid, Out_Data, Out_Sop, Out_Eop}), 64'(prev_out));
        if (Out_Valid && !Out_Ready) check("stall_no_pop", 64'(FOutN), 64'(1));
        prev_stall = Out_Valid && !Out_Ready;
        prev_out   = {Out_Valid, Out_Data, Out_Sop, Out_Eop};
        if (Out_Valid && Out_Ready) begin
            got.push_back(xfer_t'({Out_Data, Out_Sop, Out_Eop}));
            if (Out_Eop) saw_eop = 1'b1;
        end
        @(posedge Clk);
        #1;
        if (popped && fq.size() > 0) begin
            fq.delete(0);
            pops++;
        end
        fifo_refresh();
        @(negedge Clk);
    endtask

    task automatic cyc(input logic en, input logic rdy);
        Enable    = en;
        Out_Ready = rdy;
        #1;
        advance();
    endtask

    task automatic run_pkt(input string nm, input int budget, input logic tog, input int en_cycles);
        for (int i = 0; i < budget && !saw_eop; i++) begin
            cyc(i < en_cycles, tog ? RDY_PAT[i % 4] : 1'b1);
        end
        check({nm, "_eop_seen"}, 64'(saw_eop), 64'(1));
    endtask

    task automatic check_pkt(input string nm, input logic [15:0] seq, input logic [31:0] base);
        xfer_t exp;
        check({nm, "_len"}, 64'(got.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            if (i == 0) exp = {8'hA5, 8'h04, seq, 1'b1, 1'b0};
            else        exp = {base + 32'(i), 1'b0, (i == 4)};
            if (i < got.size()) check($sformatf("%s_w%0d", nm, i), 64'(got[i]), 64'(exp));
        end
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 1; i <= n; i++) fq.push_back(base + 32'(i));
        fifo_refresh();
    endtask

    function automatic vec_t mk(input logic en, input logic rdy, input logic ev,
                                input logic [31:0] ed, input logic es, input logic ee,
                                input logic ef, input logic eb, input logic [15:0] eseq);
        vec_t v;
        v.en = en; v.rdy = rdy; v.ev = ev; v.ed = ed; v.es = es; v.ee = ee;
        v.ef = ef; v.eb = eb; v.eseq = eseq;
        return v;
    endfunction

    initial begin
        int pops0;
        logic [52:0] act_v;
        logic [52:0] exp_v;

        //            en    rdy   ev    data          sop   eop   FOutN Busy  seq
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b1, 32'hA5040000, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b1, 32'h2,        1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        tbl[5]  = mk(1'b1, 1'b1, 1'b1, 32'h3,        1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
        tbl[6]  = mk(1'b1, 1'b1, 1'b1, 32'h4,        1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
        tbl[8]  = mk(1'b1, 1'b1, 1'b1, 32'hA5040001, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 32'h5,        1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        tbl[10] = mk(1'b1, 1'b1, 1'b1, 32'h6,        1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 32'h7,        1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
        tbl[12] = mk(1'b0, 1'b1, 1'b1, 32'h8,        1'b0, 1'b1, 1'b1, 1'b0, 16'd2);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 16'd2);

        // Asynchronous reset, checked before the first clock edge.
        RstN = 1'b0; Enable = 1'b0; Out_Ready = 1'b1;
        saw_eop = 1'b0; prev_stall = 1'b0; prev_out = '0;
        fifo_refresh();
        #2;
        check("reset_outputs", 64'({Out_Valid, Out_Sop, Out_Eop, Busy, FOutN, SeqNum, Out_Data}),
              64'({4'b0000, 1'b1, 16'h0000, 32'h0}));
        @(negedge Clk);
        @(negedge Clk);
        RstN = 1'b1;

        // Back-to-back: two packets from 8 preloaded words.
        push_words(32'h0, 8);
        for (int i = 0; i < 14; i++) begin
            Enable = tbl[i].en; Out_Ready = tbl[i].rdy;
            #1;
            act_v = {Out_Valid, FOutN, Busy, SeqNum, tbl[i].ev ? {Out_Data, Out_Sop, Out_Eop} : 34'h0};
            exp_v = {tbl[i].ev, tbl[i].ef, tbl[i].eb, tbl[i].eseq,
                     tbl[i].ev ? {tbl[i].ed, tbl[i].es, tbl[i].ee} : 34'h0};
            check($sformatf("vec%0d", i), 64'(act_v), 64'(exp_v));
            advance();
        end
        check("b2b_fifo_empty", 64'(fq.size()), 64'(0));

        // FIFO starvation mid-packet.
        got.delete(); saw_eop = 1'b0;
        push_words(32'h10, 2);
        for (int i = 0; i < 5; i++) begin
            Enable = (i == 0); Out_Ready = 1'b1;
            #1;
            if (i == 4) check("starve_fout_busy", 64'({FOutN, Busy}), 64'(2'b11));
            advance();
        end
        check("starve_partial_len", 64'(got.size()), 64'(3));
        push_words(32'h12, 2);
        run_pkt("starve", 30, 1'b0, 0);
        check_pkt("starve", 16'd2, 32'h10);
        check("starve_seq", 64'(SeqNum), 64'(3));

        // Backpressure with Out_Ready cycling 1,0,0,1.
        got.delete(); saw_eop = 1'b0;
        pops0 = pops;
        push_words(32'h20, 4);
        run_pkt("bp", 40, 1'b1, 40);
        Enable = 1'b0;
        check_pkt("bp", 16'd3, 32'h20);
        check("bp_pops", 64'(pops - pops0), 64'(4));
        check("bp_seq", 64'(SeqNum), 64'(4));

        // Reset after the second payload word leaves.
        got.delete(); saw_eop = 1'b0;
        push_words(32'h30, 4);
        for (int i = 0; i < 20 && got.size() < 3; i++) cyc(i == 0, 1'b1);
        check("rst_pre_len", 64'(got.size()), 64'(3));
        #2 RstN = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({Out_Valid, Out_Sop, Out_Eop, Busy, FOutN, SeqNum, Out_Data}),
              64'({4'b0000, 1'b1, 16'h0000, 32'h0}));
        @(negedge Clk);
        @(negedge Clk);
        fq.delete();
        got.delete(); saw_eop = 1'b0; prev_stall = 1'b0;
        push_words(32'h40, 4);
        RstN = 1'b1;
        run_pkt("rst", 30, 1'b0, 1);
        check_pkt("rst", 16'd0, 32'h40);
        check("rst_seq", 64'(SeqNum), 64'(1));

        // Enable dropped during DATA: packet finishes, no new header.
        got.delete(); saw_eop = 1'b0;
        push_words(32'h50, 4);
        run_pkt("endrop", 30, 1'b0, 3);
        check_pkt("endrop", 16'd1, 32'h50);
        push_words(32'h60, 4);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
        check("endrop_no_hdr", 64'({got.size(), Busy, Out_Valid}), 64'({32'd5, 1'b0, 1'b0}));
        check("endrop_fifo_kept", 64'(fq.size()), 64'(4));

        // SeqNum wrap.
        got.delete(); saw_eop = 1'b0;
        force dut.seq_q = 16'hFFFF;
        @(posedge Clk);
        #1;
        release dut.seq_q;
        @(negedge Clk);
        #1;
        check("wrap_forced", 64'(SeqNum), 64'(16'hFFFF));
        @(negedge Clk);
        run_pkt("wrap", 30, 1'b0, 1);
        check_pkt("wrap", 16'hFFFF, 32'h60);
        check("wrap_seq", 64'(SeqNum), 64'(16'h0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
